// File: rtl/sseg_scan_ctrl_pkg.sv
// Seven-segment scan controller shared types and constants.
// Glyph table, dark pattern and anode one-hot helper.
package sseg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low cathode patterns {g,f,e,d,c,b,a}, index = nibble.
  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [7:0] an_onehot(
    input logic [2:0] idx,
    input logic       act_low
  );
    logic [7:0] v;
    v = 8'd1 << idx;
    return act_low ? ~v : v;
  endfunction

endpackage

// File: rtl/sseg_scan_ctrl_if.sv
// Display data/control bundle for the scan controller.
// master drives data and controls; slave drives the display pins.
interface sseg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   blink_en;
  logic                    load;
  logic                    hex_mode;
  logic                    lz_suppress;
  logic [6:0]              seg_cat;
  logic                    seg_dp;
  logic [NUM_DIGITS-1:0]   seg_an;
  logic                    frame_done;

  modport master (
    output value, dp_in, blank_mask, blink_en,
    output load, hex_mode, lz_suppress,
    input  seg_cat, seg_dp, seg_an, frame_done
  );

  modport slave (
    input  value, dp_in, blank_mask, blink_en,
    input  load, hex_mode, lz_suppress,
    output seg_cat, seg_dp, seg_an, frame_done
  );
endinterface

// File: rtl/sseg_scan_ctrl_glyph_dec.sv
// Nibble to active-low cathode pattern.
// Codes 10-15 go dark unless hex mode is on.
import sseg_pkg::*;

module sseg_glyph_dec (
  input  logic [3:0] nib_i,
  input  logic       hex_mode_i,
  output logic [6:0] cat_o
);

  // Table lookup with decimal-only gating.
  always_comb begin
    cat_o = GLYPH[nib_i];
    if (!hex_mode_i && (nib_i > 4'd9)) begin
      cat_o = SEG_OFF;
    end
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multi-digit seven-segment scan controller with frame-aligned
// value loading, blanking, blinking and leading-zero suppression.
import sseg_pkg::*;

module sseg_scan_ctrl #(
  parameter int NUM_DIGITS       = 4,
  parameter int TICK_DIV         = 16384,
  parameter int BLINK_FRAMES     = 64,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input logic             clk,
  input logic             rst,
  sseg_scan_ctrl_if.slave bus
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int BW =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int VW = 4 * NUM_DIGITS;
  localparam int ND = NUM_DIGITS;

  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [2:0]    IDX_MAX = 3'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_FRAMES - 1);
  localparam logic          ACT_LOW = (ANODE_ACTIVE_LOW != 0);
  localparam logic [ND-1:0] AN_OFF  = {ND{ACT_LOW}};

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [BW-1:0] blk_q, blk_d;
  logic          phase_q, phase_d;
  logic [VW-1:0] pend_q, pend_d;
  logic [ND-1:0] pdp_q, pdp_d;
  logic          pv_q, pv_d;
  logic [VW-1:0] disp_q, disp_d;
  logic [ND-1:0] ddp_q, ddp_d;
  logic [6:0]    cat_q, cat_d;
  logic          dp_q, dp_d;
  logic [ND-1:0] an_q, an_d;

  logic          tick;
  logic          fd;
  logic [ND-1:0] sel_oh;
  logic [VW-1:0] disp_sh;
  logic [3:0]    nib;
  logic [6:0]    glyph;
  logic          dark;

  assign tick = (cnt_q == CNT_MAX);
  assign fd   = tick && (idx_q == IDX_MAX);

  assign bus.seg_cat    = cat_q;
  assign bus.seg_dp     = dp_q;
  assign bus.seg_an     = an_q;
  assign bus.frame_done = fd;

  sseg_glyph_dec u_glyph (
    .nib_i      (nib),
    .hex_mode_i (bus.hex_mode),
    .cat_o      (glyph)
  );

  // Prescaler, digit index and blink phase.
  always_comb begin
    cnt_d   = tick ? '0 : cnt_q + CW'(1);
    idx_d   = idx_q;
    blk_d   = blk_q;
    phase_d = phase_q;
    if (tick) begin
      idx_d = (idx_q == IDX_MAX) ? 3'd0 : idx_q + 3'd1;
    end
    if (fd) begin
      if (blk_q == BLK_MAX) begin
        blk_d   = '0;
        phase_d = ~phase_q;
      end else begin
        blk_d = blk_q + BW'(1);
      end
    end
  end

  // Pending/display shadow: display only moves at frame end.
  always_comb begin
    pend_d = pend_q;
    pdp_d  = pdp_q;
    pv_d   = pv_q;
    disp_d = disp_q;
    ddp_d  = ddp_q;
    if (bus.load) begin
      pend_d = bus.value;
      pdp_d  = bus.dp_in;
      pv_d   = 1'b1;
    end
    if (fd) begin
      if (bus.load) begin
        disp_d = bus.value;
        ddp_d  = bus.dp_in;
        pv_d   = 1'b0;
      end else if (pv_q) begin
        disp_d = pend_q;
        ddp_d  = pdp_q;
        pv_d   = 1'b0;
      end
    end
  end

  // Next-slot pattern, latched on tick from the new index.
  always_comb begin
    sel_oh  = ND'(an_onehot(idx_d, 1'b0));
    disp_sh = disp_d >> {idx_d, 2'b00};
    nib     = disp_sh[3:0];
    dark    = |(bus.blank_mask & sel_oh)
           || (|(bus.blink_en & sel_oh) && !phase_d)
           || (!bus.hex_mode && (nib > 4'd9))
           || (bus.lz_suppress && (idx_d != 3'd0)
               && (disp_sh == '0));
    cat_d = cat_q;
    dp_d  = dp_q;
    an_d  = an_q;
    if (tick) begin
      cat_d = dark ? SEG_OFF : glyph;
      dp_d  = dark || !(|(ddp_d & sel_oh));
      an_d  = ND'(an_onehot(idx_d, ACT_LOW));
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      blk_q   <= '0;
      phase_q <= 1'b1;
      pend_q  <= '0;
      pdp_q   <= '0;
      pv_q    <= 1'b0;
      disp_q  <= '0;
      ddp_q   <= '0;
      cat_q   <= SEG_OFF;
      dp_q    <= 1'b1;
      an_q    <= AN_OFF;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      blk_q   <= blk_d;
      phase_q <= phase_d;
      pend_q  <= pend_d;
      pdp_q   <= pdp_d;
      pv_q    <= pv_d;
      disp_q  <= disp_d;
      ddp_q   <= ddp_d;
      cat_q   <= cat_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end

endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
- Parametrised multi-digit seven-segment scan controller.
- Time-multiplexes NUM_DIGITS hex/decimal nibbles onto one shared cathode bus plus decimal point.
- Adds tearing-free value loading, per-digit blanking and blinking, leading-zero suppression and hex mode.
- Sits between CPU/debug logic (score, PC, register display) and the board's common-anode display.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
TICK_DIV, 16384, clk cycles per digit slot (>=2)
BLINK_FRAMES, 64, full scan frames per blink half-period (>=1)
ANODE_ACTIVE_LOW, 1, 1 = selected anode driven 0; 0 = driven 1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
value  in  4*NUM_DIGITS  digit nibbles; digit 0 = value[3:0] (rightmost)
dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit
blank_mask  in  NUM_DIGITS  1 = digit forced dark
blink_en  in  NUM_DIGITS  1 = digit dark during blink-off phase
load  in  1  one-cycle strobe; captures value/dp_in into pending registers
hex_mode  in  1  1 = codes A-F shown; 0 = codes 10-15 dark
lz_suppress  in  1  1 = leading zeros dark
seg_cat  out  7  cathodes {g,f,e,d,c,b,a}, active low
seg_dp  out  1  decimal point, active low
seg_an  out  NUM_DIGITS  anode enables, polarity per ANODE_ACTIVE_LOW
frame_done  out  1  one-cycle pulse when the last digit slot ends

Behaviour:
- Reset (async, active-high):
  - Prescaler, digit index, blink counter: 0. Blink phase: on.
  - Pending and display registers: 0. Pending-valid flag: 0.
  - Outputs: seg_cat 7'h7F, seg_dp 1, seg_an all inactive, frame_done 0.
  - Outputs stay dark until the first tick after reset deasserts.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick = 1 in the cycle the count equals TICK_DIV-1.
- Digit index: advances on tick; wraps NUM_DIGITS-1 -> 0. frame_done = tick && index == NUM_DIGITS-1.
- Load:
  - On load, value/dp_in go to pending registers and pending-valid is set.
  - A second load before the frame boundary overwrites pending; the last one wins.
  - On frame_done with pending-valid, pending copies to display and pending-valid clears. The display never changes mid-frame.
  - If load and frame_done coincide, the new value is written straight to display.
- Blink: blink counter counts frame_done pulses. At BLINK_FRAMES-1 it wraps to 0 and the phase toggles.
- blank_mask, blink_en, hex_mode, lz_suppress are sampled live (not shadowed).
- A digit is dark if any of:
  - its blank_mask bit is set;
  - its blink_en bit is set and the phase is off;
  - hex_mode = 0 and its nibble > 9;
  - lz_suppress = 1, its nibble is 0, every higher digit is 0, and it is not digit 0.
- A dark digit drives cathodes 7'h7F and dp 1. Its anode still scans, keeping duty constant.
- Glyphs (active low):
  - 0 1000000, 1 1111001, 2 0100100, 3 0110000, 4 0011001
  - 5 0010010, 6 0000010, 7 1111000, 8 0000000, 9 0010000
  - A 0001000, b 0000011, C 1000110, d 0100001, E 0000110, F 0001110
- Output timing:
  - seg_cat, seg_dp, seg_an are registered and updated in the cycle after tick, from the new index. Latency is 1 cycle from tick.
  - Exactly one anode is active after the first tick.
- Reset mid-frame: all state clears immediately; a frame in progress is abandoned and pending data is lost.

Decomposition:
- Package sseg_pkg:
  - 16-entry glyph constants
  - SEG_OFF = 7'h7F
  - Helper function for anode one-hot with polarity.
- Sub-module sseg_glyph_dec: combinational nibble + hex_mode -> 7-bit cathode pattern.
- Leading-zero, blank and blink logic, counters and shadow registers stay in the top.

Test Plan:
- Reset, then load 16'h1234 with TICK_DIV=4 -> after the next frame_done, anodes cycle 1110,1101,1011,0111 every 4 clk; cathodes 0011001, 0110000, 0100100, 1111001 for digits 0..3.
- Load 16'h00AB with hex_mode=0 -> digits 0-1 dark (7F). With hex_mode=1 -> digit1 0001000, digit0 0000011.
- Load 16'h0005, lz_suppress=1 -> digits 3-2-1 dark, digit 0 0010010. Load 16'h0000 -> only digit 0 shows 1000000.
- Load 16'h1111 mid-frame, then load 16'h2222 before frame_done -> displayed digits never show 1; they show 0100100 from the next frame.
- blink_en=4'b0001, BLINK_FRAMES=2 -> digit 0 alternates lit/dark every 2 frames; digits 1-3 always lit. blank_mask bit 2 -> digit 2 always 7F.
- Assert rst mid-slot -> same cycle: seg_an all inactive, seg_cat 7F, frame_done 0. Previous value is not redisplayed until a new load.
